// File: rtl/uncache_mmio_split.sv
// Routes LSU accesses to the dcache (cached) or splits them into BUS_W arbiter beats (uncached MMIO).
// Latency: cached path is combinational; uncached path is NB*(bus latency+1)+1 cycles, or less when beats are skipped.
// Backpressure: the core holds core_we/core_re until in_core_finish; each beat waits for in_arb_finish or a timeout.
//
// Ports: clk/rst_n; core_* request in, in_core_* response out; arb_* beat request out, in_arb_* beat response in;
//        dcache_* request out, in_dcache_* response in; mmio_sign flags CLINT accesses; fence_in forwarded to dcache_fence.
module uncache_mmio_split #(
    parameter int DATA_W     = 64,
    parameter int BUS_W      = 32,
    parameter int REGION_NUM = 4,
    // region 0 (UART) in the least significant 64 bits: {CLINT, SPI, SPICTRL, UART}
    parameter logic [REGION_NUM*64-1:0] REGION_BASE = {64'h0000_0000_0200_0000, 64'h0000_0000_3000_0000,
                                                       64'h0000_0000_1000_1000, 64'h0000_0000_1000_0000},
    parameter logic [REGION_NUM*64-1:0] REGION_END  = {64'h0000_0000_0200_FFFF, 64'h0000_0000_3FFF_FFFF,
                                                       64'h0000_0000_1000_1FFF, 64'h0000_0000_1000_0FFF},
    parameter int CLINT_IDX  = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [2:0]          mmio_sign,
    input  logic [63:0]         core_addr,
    input  logic [DATA_W-1:0]   core_data,
    input  logic [DATA_W/8-1:0] core_mask,
    input  logic                core_we,
    input  logic                core_re,
    input  logic                fence_in,
    output logic [DATA_W-1:0]   in_core_data,
    output logic                in_core_finish,
    output logic                in_core_err,
    output logic [63:0]         arb_addr,
    output logic [BUS_W-1:0]    arb_data,
    output logic [BUS_W/8-1:0]  arb_mask,
    output logic                arb_we,
    output logic                arb_re,
    input  logic [BUS_W-1:0]    in_arb_data,
    input  logic                in_arb_finish,
    output logic [63:0]         dcache_addr,
    output logic [DATA_W-1:0]   dcache_data,
    output logic [DATA_W/8-1:0] dcache_mask,
    output logic                dcache_fence,
    output logic                dcache_we,
    output logic                dcache_re,
    input  logic [DATA_W-1:0]   in_dcache_data,
    input  logic                in_dcache_finish
);

    localparam int NB  = DATA_W / BUS_W;
    localparam int MB  = BUS_W / 8;
    localparam int KW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int OFS = $clog2(DATA_W / 8);
    localparam int BO  = $clog2(BUS_W / 8);
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [63:OFS]         addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DATA_W/8-1:0]   mask_q, mask_d;
    logic                  we_q, we_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]     rbuf_q, rbuf_d;
    logic                  err_q, err_d;
    logic [63:0]           arb_addr_q, arb_addr_d;
    logic [BUS_W-1:0]      arb_data_q, arb_data_d;
    logic [MB-1:0]         arb_mask_q, arb_mask_d;
    logic                  arb_re_q, arb_re_d;
    logic                  arb_we_q, arb_we_d;

    logic [REGION_NUM-1:0] hit;
    logic                  req, uncached, cached_req;
    logic [KW-1:0]         first_k, nxt_k;
    logic                  any_beat, has_nxt;

    // Region classification, bounds inclusive
    always_comb begin
        hit = '0;
        for (int i = 0; i < REGION_NUM; i++) begin
            hit[i] = (core_addr >= REGION_BASE[i*64 +: 64]) && (core_addr <= REGION_END[i*64 +: 64]);
        end
    end

    assign req        = core_we | core_re;
    assign uncached   = |hit;
    assign cached_req = req & ~uncached;
    assign mmio_sign  = (req && hit[CLINT_IDX]) ? 3'b010 : 3'b100;

    // Lowest beat with a nonzero mask slice (new request), and the next one after k_q (in flight).
    // Descending loops: the last hit written is the lowest qualifying index.
    always_comb begin
        first_k  = '0;
        any_beat = 1'b0;
        nxt_k    = '0;
        has_nxt  = 1'b0;
        for (int j = NB - 1; j >= 0; j--) begin
            if (core_mask[j*MB +: MB] != '0) begin
                first_k  = KW'(j);
                any_beat = 1'b1;
            end
            if ((j > int'(k_q)) && (mask_q[j*MB +: MB] != '0)) begin
                nxt_k   = KW'(j);
                has_nxt = 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        we_d       = we_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        rbuf_d     = rbuf_q;
        err_d      = err_q;
        arb_addr_d = arb_addr_q;
        arb_data_d = arb_data_q;
        arb_mask_d = arb_mask_q;
        arb_re_d   = arb_re_q;
        arb_we_d   = arb_we_q;
        case (state_q)
            IDLE: begin
                if (req && uncached) begin
                    addr_d  = core_addr[63:OFS];
                    data_d  = core_data;
                    mask_d  = core_mask;
                    we_d    = core_we;      // both enables high means write
                    rbuf_d  = '0;
                    err_d   = 1'b0;
                    k_d     = first_k;
                    state_d = any_beat ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                // The bus request is low for this one cycle; it rises when WAIT is entered
                arb_addr_d = {addr_q, {OFS{1'b0}}} | (64'(k_q) << BO);
                arb_data_d = data_q[k_q*BUS_W +: BUS_W];
                arb_mask_d = mask_q[k_q*MB +: MB];
                arb_re_d   = ~we_q;
                arb_we_d   = we_q;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // finish is checked first so it beats a same-cycle timeout
                if (in_arb_finish) begin
                    if (!we_q) begin
                        rbuf_d[k_q*BUS_W +: BUS_W] = in_arb_data;
                    end
                    arb_re_d = 1'b0;
                    arb_we_d = 1'b0;
                    if (has_nxt) begin
                        k_d     = nxt_k;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end else if ((TIMEOUT > 0) && (cnt_q == TO_V)) begin
                    arb_re_d = 1'b0;
                    arb_we_d = 1'b0;
                    rbuf_d   = '1;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            we_q       <= 1'b0;
            k_q        <= '0;
            cnt_q      <= '0;
            rbuf_q     <= '0;
            err_q      <= 1'b0;
            arb_addr_q <= '0;
            arb_data_q <= '0;
            arb_mask_q <= '0;
            arb_re_q   <= 1'b0;
            arb_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            we_q       <= we_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            rbuf_q     <= rbuf_d;
            err_q      <= err_d;
            arb_addr_q <= arb_addr_d;
            arb_data_q <= arb_data_d;
            arb_mask_q <= arb_mask_d;
            arb_re_q   <= arb_re_d;
            arb_we_q   <= arb_we_d;
        end
    end

    assign arb_addr     = arb_addr_q;
    assign arb_data     = arb_data_q;
    assign arb_mask     = arb_mask_q;
    assign arb_re       = arb_re_q;
    assign arb_we       = arb_we_q;
    assign dcache_fence = fence_in;

    // Response / dcache muxing by state
    always_comb begin
        dcache_addr    = '0;
        dcache_data    = '0;
        dcache_mask    = '0;
        dcache_we      = 1'b0;
        dcache_re      = 1'b0;
        in_core_data   = '0;
        in_core_finish = 1'b0;
        in_core_err    = 1'b0;
        case (state_q)
            IDLE: begin
                in_core_data = in_dcache_data;
                if (cached_req) begin
                    dcache_addr    = core_addr;
                    dcache_data    = core_data;
                    dcache_mask    = core_mask;
                    dcache_we      = core_we;
                    dcache_re      = core_re;
                    in_core_finish = in_dcache_finish;
                end
            end
            DONE: begin
                in_core_data   = we_q ? '0 : rbuf_q;
                in_core_finish = 1'b1;
                in_core_err    = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uncache_mmio_split.sv
module tb_uncache_mmio_split;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mmio_sign;
    logic [63:0] core_addr, core_data;
    logic [7:0]  core_mask;
    logic        core_we, core_re, fence_in;
    logic [63:0] in_core_data;
    logic        in_core_finish, in_core_err;
    logic [63:0] arb_addr;
    logic [31:0] arb_data;
    logic [3:0]  arb_mask;
    logic        arb_we, arb_re;
    logic [31:0] in_arb_data;
    logic        in_arb_finish;
    logic [63:0] dcache_addr, dcache_data;
    logic [7:0]  dcache_mask;
    logic        dcache_fence, dcache_we, dcache_re;
    logic [63:0] in_dcache_data;
    logic        in_dcache_finish;

    uncache_mmio_split #(.DATA_W(64), .BUS_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .mmio_sign(mmio_sign),
        .core_addr(core_addr), .core_data(core_data), .core_mask(core_mask),
        .core_we(core_we), .core_re(core_re), .fence_in(fence_in),
        .in_core_data(in_core_data), .in_core_finish(in_core_finish), .in_core_err(in_core_err),
        .arb_addr(arb_addr), .arb_data(arb_data), .arb_mask(arb_mask), .arb_we(arb_we), .arb_re(arb_re),
        .in_arb_data(in_arb_data), .in_arb_finish(in_arb_finish),
        .dcache_addr(dcache_addr), .dcache_data(dcache_data), .dcache_mask(dcache_mask),
        .dcache_fence(dcache_fence), .dcache_we(dcache_we), .dcache_re(dcache_re),
        .in_dcache_data(in_dcache_data), .in_dcache_finish(in_dcache_finish)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus responder: finishes a beat after bus_lat cycles of request, logs every beat
    int          bus_lat   = 2;
    int          hang_beat = 8;     // beats with index >= hang_beat never finish
    logic [31:0] resp [2];
    int          n_beats   = 0;
    logic        arb_seen  = 1'b0;
    logic [63:0] b_addr [8];
    logic [31:0] b_dat  [8];
    logic [3:0]  b_msk  [8];
    logic        b_we   [8];
    int          b_start[8];

    initial begin
        int wcnt;
        wcnt          = 0;
        in_arb_finish = 1'b0;
        in_arb_data   = '0;
        forever begin
            @(negedge clk);
            in_arb_finish = 1'b0;
            if (!rst_n || !(arb_re || arb_we)) begin
                wcnt = 0;
            end else begin
                wcnt++;
                arb_seen = 1'b1;
                if (wcnt == 1 && n_beats < 8) begin
                    b_addr[n_beats]  = arb_addr;
                    b_dat[n_beats]   = arb_data;
                    b_msk[n_beats]   = arb_mask;
                    b_we[n_beats]    = arb_we;
                    b_start[n_beats] = cyc;
                    n_beats++;
                end
                if (wcnt >= bus_lat && (n_beats - 1) < hang_beat) begin
                    in_arb_finish = 1'b1;
                    in_arb_data   = resp[(n_beats - 1) % 2];
                end
            end
        end
    end

    logic [2:0] sig_at_req;
    logic       dcre_at_req;
    int         fin_cyc;

    task automatic run_txn(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                           input logic w, input logic r, input int budget,
                           output int lat, output logic [63:0] dat, output logic err);
        @(negedge clk);
        n_beats   = 0;
        arb_seen  = 1'b0;
        core_addr = a; core_data = d; core_mask = m; core_we = w; core_re = r;
        #1;
        sig_at_req  = mmio_sign;
        dcre_at_req = dcache_re;
        lat = 0;
        while (!in_core_finish && lat < budget) begin
            @(negedge clk); #1;
            lat++;
        end
        chk("finish_seen", {63'd0, in_core_finish}, 64'd1);
        dat     = in_core_data;
        err     = in_core_err;
        fin_cyc = cyc;
        core_we = 1'b0; core_re = 1'b0;
        @(negedge clk); #1;
        chk("finish_one_cycle", {63'd0, in_core_finish}, 64'd0);
    endtask

    task automatic cached_rd(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        arb_seen  = 1'b0;
        core_addr = a; core_data = 64'h0; core_mask = 8'hFF; core_re = 1'b1; core_we = 1'b0; fence_in = 1'b1;
        #1;
        chk("c_dcache_re",  {63'd0, dcache_re}, 64'd1);
        chk("c_dcache_addr", dcache_addr, a);
        chk("c_fence",      {63'd0, dcache_fence}, 64'd1);
        chk("c_mmio_sign",  {61'd0, mmio_sign}, 64'd4);
        chk("c_no_finish_yet", {63'd0, in_core_finish}, 64'd0);
        repeat (3) @(negedge clk);
        in_dcache_data = d; in_dcache_finish = 1'b1;
        #1;
        chk("c_finish", {63'd0, in_core_finish}, 64'd1);
        chk("c_data",   in_core_data, d);
        chk("c_err",    {63'd0, in_core_err}, 64'd0);
        @(negedge clk);
        core_re = 1'b0; in_dcache_finish = 1'b0; fence_in = 1'b0;
        #1;
        chk("c_dcache_idle", {63'd0, dcache_re}, 64'd0);
        chk("c_no_arb",      {63'd0, arb_seen}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [63:0] dat;
        logic        err;
        logic        fin_any;

        rst_n = 1'b0;
        core_addr = '0; core_data = '0; core_mask = '0; core_we = 1'b0; core_re = 1'b0; fence_in = 1'b0;
        in_dcache_data = 64'h55; in_dcache_finish = 1'b0;
        resp[0] = '0; resp[1] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_arb_re",   {63'd0, arb_re}, 64'd0);
        chk("rst_arb_we",   {63'd0, arb_we}, 64'd0);
        chk("rst_arb_addr", arb_addr, 64'd0);
        chk("rst_finish",   {63'd0, in_core_finish}, 64'd0);
        chk("rst_err",      {63'd0, in_core_err}, 64'd0);
        chk("rst_data_follows_dcache", in_core_data, 64'h55);
        @(negedge clk);
        rst_n = 1'b1;

        // Cached read
        cached_rd(64'h8000_0000, 64'h1122_3344_5566_7788);

        // Uncached UART read, two beats
        bus_lat = 2; hang_beat = 8; resp[0] = 32'hAAAA_0000; resp[1] = 32'h0000_BBBB;
        run_txn(64'h1000_0000, 64'h0, 8'hFF, 1'b0, 1'b1, 40, lat, dat, err);
        chk("u_sign",      {61'd0, sig_at_req}, 64'd4);
        chk("u_no_dcache", {63'd0, dcre_at_req}, 64'd0);
        chk("u_latency",   64'(lat), 64'd7);
        chk("u_data",      dat, 64'h0000_BBBB_AAAA_0000);
        chk("u_err",       {63'd0, err}, 64'd0);
        chk("u_beats",     64'(n_beats), 64'd2);
        chk("u_addr0",     b_addr[0], 64'h1000_0000);
        chk("u_addr1",     b_addr[1], 64'h1000_0004);
        chk("u_re_op",     {63'd0, b_we[0]}, 64'd0);
        chk("u_gap",       64'(b_start[1] - b_start[0]), 64'd3);

        // Uncached CLINT write, upper beat only
        run_txn(64'h0200_0000, 64'hDEAD_BEEF_0123_4567, 8'hF0, 1'b1, 1'b0, 40, lat, dat, err);
        chk("w_sign",    {61'd0, sig_at_req}, 64'd2);
        chk("w_latency", 64'(lat), 64'd4);
        chk("w_beats",   64'(n_beats), 64'd1);
        chk("w_addr",    b_addr[0], 64'h0200_0004);
        chk("w_data",    {32'd0, b_dat[0]}, 64'hDEAD_BEEF);
        chk("w_mask",    {60'd0, b_msk[0]}, 64'hF);
        chk("w_we",      {63'd0, b_we[0]}, 64'd1);
        chk("w_core_data_zero", dat, 64'd0);

        // Timeout: bus never answers
        hang_beat = 0;
        run_txn(64'h1000_0008, 64'h0, 8'hFF, 1'b0, 1'b1, 40, lat, dat, err);
        chk("t_latency",   64'(lat), 64'd11);
        chk("t_issue2fin", 64'(fin_cyc - b_start[0]), 64'd9);
        chk("t_err",       {63'd0, err}, 64'd1);
        chk("t_data",      dat, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t_beats",     64'(n_beats), 64'd1);
        chk("t_addr",      b_addr[0], 64'h1000_0008);

        // Zero mask, both enables: no bus activity
        hang_beat = 8;
        run_txn(64'h1000_0010, 64'h1234, 8'h00, 1'b1, 1'b1, 40, lat, dat, err);
        chk("z_latency", 64'(lat), 64'd1);
        chk("z_beats",   64'(n_beats), 64'd0);
        chk("z_data",    dat, 64'd0);
        chk("z_err",     {63'd0, err}, 64'd0);

        // Both enables with a live mask: must be issued as a write
        run_txn(64'h1000_0020, 64'h1234_5678_CAFE_F00D, 8'h0F, 1'b1, 1'b1, 40, lat, dat, err);
        chk("d_latency", 64'(lat), 64'd4);
        chk("d_beats",   64'(n_beats), 64'd1);
        chk("d_we",      {63'd0, b_we[0]}, 64'd1);
        chk("d_addr",    b_addr[0], 64'h1000_0020);
        chk("d_data",    {32'd0, b_dat[0]}, 64'hCAFE_F00D);
        chk("d_mask",    {60'd0, b_msk[0]}, 64'hF);

        // Reset in the middle of beat 1's wait
        hang_beat = 1;
        @(negedge clk);
        n_beats = 0;
        core_addr = 64'h1000_0000; core_mask = 8'hFF; core_re = 1'b1; core_we = 1'b0;
        for (int i = 0; i < 30 && n_beats < 2; i++) begin
            @(negedge clk); #1;
        end
        chk("r_reached_beat1", 64'(n_beats), 64'd2);
        chk("r_arb_re_high",   {63'd0, arb_re}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_arb_re_async_drop", {63'd0, arb_re}, 64'd0);
        core_re = 1'b0;
        fin_any = in_core_finish;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            fin_any = fin_any | in_core_finish;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            fin_any = fin_any | in_core_finish;
        end
        chk("r_no_finish", {63'd0, fin_any}, 64'd0);
        hang_beat = 8;
        cached_rd(64'h8000_1000, 64'h0F0E_0D0C_0B0A_0908);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uncache_mmio_split.md
Name: uncache_mmio_split

Overview:
- Clocked successor of the combinational uncache router between the LSU and the data cache / AXI arbiter.
- Classifies each core access against a parametrised table of uncached regions.
- Cached accesses pass to the dcache unchanged. Uncached accesses are registered and split into DATA_W/BUS_W sequential bus beats by an FSM.
- Adds mask-based beat skipping and a per-beat timeout with an error flag.

Parameters:
- DATA_W, 64, core data width in bits.
- BUS_W, 32, arbiter beat width in bits. DATA_W/BUS_W is a power of two, 1..8.
- REGION_NUM, 4, number of uncached regions.
- REGION_BASE, {UART,SPICTRL,SPI,CLINT starts}, packed REGION_NUM×64 inclusive start addresses; region 0 is in the least significant 64 bits.
- REGION_END, {matching ends}, packed REGION_NUM×64 inclusive end addresses.
- CLINT_IDX, 3, region index that drives mmio_sign=3'b010.
- TIMEOUT, 255, maximum cycles to wait for in_arb_finish on one beat. 0 disables the timeout.

Ports:
- clk in 1: clock, rising edge.
- rst_n in 1: asynchronous reset, active-low.
- mmio_sign out 3: 3'b010 if (core_we|core_re) and the address is in region CLINT_IDX, else 3'b100. Combinational.
- core_addr in 64; core_data in DATA_W; core_mask in DATA_W/8; core_we in 1; core_re in 1; fence_in in 1.
- in_core_data out DATA_W; in_core_finish out 1; in_core_err out 1.
- arb_addr out 64; arb_data out BUS_W; arb_mask out BUS_W/8; arb_we out 1; arb_re out 1.
- in_arb_data in BUS_W; in_arb_finish in 1.
- dcache_addr out 64; dcache_data out DATA_W; dcache_mask out DATA_W/8; dcache_fence out 1; dcache_we out 1; dcache_re out 1.
- in_dcache_data in DATA_W; in_dcache_finish in 1.

Behaviour:
- Definitions: NB=DATA_W/BUS_W; OFS=log2(DATA_W/8); BO=log2(BUS_W/8). An address is uncached if it lies in any region [BASE_i, END_i], bounds inclusive.
- Core protocol: core_we/core_re are held level-high until in_core_finish. If both are high, the access is a write.
- dcache_fence = fence_in at all times.
- State IDLE, cached request: dcache_* = core_* combinationally; in_core_data/in_core_finish = in_dcache_*; in_core_err=0. The FSM does not leave IDLE.
- In every other case, dcache_addr/data/mask/we/re are 0.
- IDLE, uncached request: latch addr, data, mask and op; beat index k = first beat whose mask slice is nonzero. Go to ISSUE.
- If the whole mask is zero: go straight to DONE with data 0 and no bus activity.
- ISSUE/WAIT: arb_re or arb_we = 1, held through WAIT.
  - arb_addr = {addr[63:OFS], k[log2NB-1:0], BO zeros}.
  - arb_mask = mask slice k; arb_data = data slice k.
- Beat order: ascending k (low half first). Beats with a zero mask slice are skipped.
- WAIT, on in_arb_finish:
  - For a read, store in_arb_data into read buffer slice k.
  - Advance to the next non-skipped beat and drop arb_re/arb_we for exactly one cycle (ISSUE re-entry).
  - If no beats remain, go to DONE.
- Skipped read slices return 0.
- Timeout: when TIMEOUT>0, a counter clears on entry to each beat and increments each WAIT cycle.
  - When it reaches TIMEOUT without finish: abandon the remaining beats, set error, read buffer = all ones, go to DONE.
  - If finish arrives on the same cycle the counter reaches TIMEOUT, the finish wins.
- DONE, one cycle: in_core_finish=1; in_core_data = read buffer (0 for writes); in_core_err = error flag. Then go to IDLE.
  - The next request is accepted no earlier than the cycle after DONE.
  - in_core_finish is never high for two consecutive cycles on the uncached path.
- Uncached latency with no skips: NB × (bus latency + 1) + 1 cycles.
- The core address is sampled only in IDLE. Changes to core_* during a transaction are ignored.
- Reset (asynchronous, any state): state=IDLE.
  - Registered outputs are 0: arb_re, arb_we, arb_addr, arb_data, arb_mask, in_core_finish, in_core_err, read buffer, counter.
  - An interrupted transaction is dropped, not replayed.
  - In IDLE, in_core_data follows in_dcache_data; it is 0 only if in_dcache_data is 0.

Test Plan:
- Cached read at 0x8000_0000, in_dcache_finish after 3 cycles with data 0x1122334455667788 -> dcache_re=1, arb_re never asserted, in_core_data matches, mmio_sign=3'b100.
- Uncached read at 0x1000_0000 (UART), mask 0xFF, bus returns 0xAAAA0000 then 0x0000BBBB, each after 2 cycles:
  - -> beats at 0x1000_0000 then 0x1000_0004;
  - -> one-cycle arb_re gap between beats;
  - -> in_core_data = 0x0000BBBB_AAAA0000, finish pulse 1 cycle.
- Uncached write at 0x0200_0000 (CLINT), mask 0xF0, data 0xDEADBEEF_01234567:
  - -> mmio_sign=3'b010;
  - -> one beat only: addr 0x0200_0004, data 0xDEADBEEF, mask 0xF.
- Uncached read, bus never finishes, TIMEOUT=8 -> finish exactly 9 cycles after beat issue, in_core_err=1, data 0xFFFF_FFFF_FFFF_FFFF.
- rst_n low mid-WAIT of beat 1 -> arb_re drops asynchronously, no finish pulse; a new cached request after release completes normally.
- Uncached access with mask 0x00, plus core_we and core_re both high -> finish in DONE with no bus beats; the dual-enable case is treated as a write.
